// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup in IF is combinational on PCF; branches resolved
// in EX produce a redirect request and train the table on the rising edge.
// Also counts resolved branches and mispredicts.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   PCF           IF-stage PC to look up
//   PredTakenF    IF prediction (hit && ctr[1]), forced low while rst is high
//   PredTargetF   predicted target, PCF+4 when not predicted taken
//   BrInstE       EX holds a live conditional branch
//   PCE           PC of the EX branch
//   BranchE       actual outcome, 1 = taken
//   BranchTarget  actual taken target
//   PredTakenE    prediction carried down with the EX branch
//   PredTargetE   predicted target carried down with the EX branch
//   MispredE      EX redirect request (combinational)
//   RedirectPC    correct next PC when MispredE is high
//   BrCount       resolved branches since reset (wraps)
//   MispredCount  mispredicts since reset (wraps)
// -----------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    input  logic             BrInstE,
    input  logic [31:0]      PCE,
    input  logic             BranchE,
    input  logic [31:0]      BranchTarget,
    input  logic             PredTakenE,
    input  logic [31:0]      PredTargetE,
    output logic             MispredE,
    output logic [31:0]      RedirectPC,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] MispredCount
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    // Valid bits and counters live in flops so reset clears them in one cycle.
    logic [ENTRIES-1:0]       valid_q, valid_d;
    logic [ENTRIES-1:0][1:0]  ctr_q, ctr_d;

    // Tag and target have no reset; they are only meaningful behind valid.
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mis_count_q, mis_count_d;

    // ---------------------------------------------------------------- lookup
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_pred_taken;

    assign f_idx        = PCF[IDX_W+1:2];
    assign f_tag        = PCF[31:IDX_W+2];
    assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    // Reset gates the prediction directly so it is low from the first cycle
    // rst is seen, before the table itself has been cleared.
    assign f_pred_taken = !rst && f_hit && ctr_q[f_idx][1];
    assign PredTakenF   = f_pred_taken;
    assign PredTargetF  = f_pred_taken ? target_q[f_idx] : (PCF + 32'd4);

    // --------------------------------------------------------------- resolve
    logic [31:0] pce_plus4;
    assign pce_plus4 = PCE + 32'd4;

    always_comb begin
        MispredE   = 1'b0;
        RedirectPC = pce_plus4;
        if (BrInstE) begin
            if (BranchE && (!PredTakenE || (PredTargetE != BranchTarget))) begin
                // Taken but predicted not-taken, or taken to a different target.
                MispredE   = 1'b1;
                RedirectPC = BranchTarget;
            end else if (!BranchE && PredTakenE) begin
                MispredE   = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- update
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic [1:0]       e_ctr;
    logic [1:0]       e_ctr_new;
    logic             e_ctr_en;
    logic             e_alloc;
    logic             e_target_en;

    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[31:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_ctr = ctr_q[e_idx];

    always_comb begin
        e_ctr_new   = e_ctr;
        e_ctr_en    = 1'b0;
        e_alloc     = 1'b0;
        e_target_en = 1'b0;
        if (BrInstE) begin
            if (e_hit) begin
                e_ctr_en = 1'b1;
                if (BranchE) begin
                    e_ctr_new   = (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'b01;
                    e_target_en = 1'b1;
                end else begin
                    e_ctr_new   = (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'b01;
                end
            end else if (BranchE) begin
                // Miss on a taken branch replaces whatever occupied the slot,
                // starting weakly taken. Not-taken misses leave the table alone.
                e_alloc     = 1'b1;
                e_ctr_en    = 1'b1;
                e_ctr_new   = 2'b10;
                e_target_en = 1'b1;
            end
        end
    end

    // Per-entry next state: only the EX-indexed entry can change.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic sel;
            assign sel         = (e_idx == IDX_W'(gi));
            assign valid_d[gi] = valid_q[gi] | (e_alloc && sel);
            assign ctr_d[gi]   = (e_ctr_en && sel) ? e_ctr_new : ctr_q[gi];
        end
    endgenerate

    assign br_count_d  = BrInstE ? br_count_q + CNT_W'(1) : br_count_q;
    assign mis_count_d = mis_count_q + CNT_W'(MispredE);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            ctr_q       <= {ENTRIES{2'b01}};
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctr_q       <= ctr_d;
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    // Reset drops any training in flight, including tag/target writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (e_alloc) begin
                tag_q[e_idx] <= e_tag;
            end
            if (e_target_en) begin
                target_q[e_idx] <= BranchTarget;
            end
        end
    end

    assign BrCount      = br_count_q;
    assign MispredCount = mis_count_q;

endmodule
